// File: rtl/div_share_arb_pkg.sv
// Shared definitions for the divider-sharing arbiter: one-hot state codes,
// the divider's fractional format and divide-by-zero saturation helpers.
package div_share_arb_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE = 3'b001;
    localparam state_t S_BUSY = 3'b010;
    localparam state_t S_DONE = 3'b100;

    localparam int DIV_FRAC_BITS = 13;

    // Bit idx of the saturated quotient for a D_W-wide result: the sign bit
    // follows the dividend sign, every other bit is its complement.
    function automatic logic sat_bit(input logic neg, input int idx, input int w);
        return (idx == w - 1) ? neg : ~neg;
    endfunction

endpackage

// File: rtl/div_share_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or above the
// pointer, wrapping around, returned both one-hot and as an index.
module div_share_arb_rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_vld
);

    localparam logic [IW:0] N_L = (IW + 1)'(N);

    logic [IW:0]   w_sum;
    logic [IW-1:0] w_cand;

    // The pointer is always below N, so a single conditional subtract wraps.
    always_comb begin
        o_gnt  = '0;
        o_idx  = '0;
        o_vld  = 1'b0;
        w_sum  = '0;
        w_cand = '0;
        for (int k = 0; k < N; k++) begin
            w_sum = {1'b0, i_ptr} + (IW + 1)'(k);
            if (w_sum >= N_L) begin
                w_sum = w_sum - N_L;
            end
            w_cand = w_sum[IW-1:0];
            if (!o_vld && i_req[w_cand]) begin
                o_vld         = 1'b1;
                o_gnt[w_cand] = 1'b1;
                o_idx         = w_cand;
            end
        end
    end

endmodule

// File: rtl/div_share_arb.sv
// Round-robin sequencer sharing one external signed fixed-point divider
// among N_REQ requesters; divide-by-zero is answered locally.
module div_share_arb
    import div_share_arb_pkg::*;
#(
    parameter int D_W   = 16,
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                 I_CLK,
    input  logic                 I_RST,
    input  logic [N_REQ-1:0]     I_REQ_VLD,
    input  logic [N_REQ*D_W-1:0] I_REQ_DIVIDEND,
    input  logic [N_REQ*D_W-1:0] I_REQ_DIVISOR,
    output logic [N_REQ-1:0]     O_REQ_RDY,
    output logic                 O_DIV_START,
    output logic [D_W-1:0]       O_DIV_DIVIDEND,
    output logic [D_W-1:0]       O_DIV_DIVISOR,
    input  logic [D_W-1:0]       I_DIV_QUOTIENT,
    input  logic                 I_DIV_VLD,
    output logic                 O_RSP_VLD,
    output logic [ID_W-1:0]      O_RSP_ID,
    output logic [D_W-1:0]       O_RSP_QUOTIENT,
    output logic                 O_RSP_DIV0,
    output logic                 O_BUSY
);

    localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);

    state_t          r_state;
    logic [ID_W-1:0] r_ptr;
    logic [ID_W-1:0] r_id;
    logic [D_W-1:0]  r_dividend;
    logic [D_W-1:0]  r_divisor;
    logic [D_W-1:0]  r_quot;
    logic            r_div0;

    logic [N_REQ-1:0] w_pick_gnt;
    logic [ID_W-1:0]  w_pick_idx;
    logic             w_pick_vld;
    logic             w_grant;
    logic [ID_W-1:0]  w_next_ptr;
    logic [D_W-1:0]   w_sel_dividend;
    logic [D_W-1:0]   w_sel_divisor;
    logic [D_W-1:0]   w_sat;

    div_share_arb_rr_pick #(
        .N  (N_REQ),
        .IW (ID_W)
    ) u_rr_pick (
        .i_req (I_REQ_VLD),
        .i_ptr (r_ptr),
        .o_gnt (w_pick_gnt),
        .o_idx (w_pick_idx),
        .o_vld (w_pick_vld)
    );

    // The done cycle is grant-eligible so back-to-back operations lose only
    // the one start-low cycle the divider needs to re-arm.
    assign w_grant        = w_pick_vld && (r_state != S_BUSY);
    assign w_next_ptr     = (w_pick_idx == LAST_ID) ? '0 : w_pick_idx + 1'b1;
    assign w_sel_dividend = I_REQ_DIVIDEND[w_pick_idx*D_W +: D_W];
    assign w_sel_divisor  = I_REQ_DIVISOR[w_pick_idx*D_W +: D_W];

    always_comb begin
        w_sat = '0;
        for (int i = 0; i < D_W; i++) begin
            w_sat[i] = sat_bit(w_sel_dividend[D_W-1], i, D_W);
        end
    end

    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_id       <= '0;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_quot     <= '0;
            r_div0     <= 1'b0;
        end else if (w_grant) begin
            r_id       <= w_pick_idx;
            r_dividend <= w_sel_dividend;
            r_divisor  <= w_sel_divisor;
            r_ptr      <= w_next_ptr;
            if (w_sel_divisor == '0) begin
                r_quot  <= w_sat;
                r_div0  <= 1'b1;
                r_state <= S_DONE;
            end else begin
                r_div0  <= 1'b0;
                r_state <= S_BUSY;
            end
        end else if (r_state == S_BUSY) begin
            if (I_DIV_VLD) begin
                r_quot  <= I_DIV_QUOTIENT;
                r_state <= S_DONE;
            end
        end else begin
            r_state <= S_IDLE;
        end
    end

    assign O_REQ_RDY      = w_grant ? w_pick_gnt : '0;
    assign O_DIV_START    = (r_state == S_BUSY);
    assign O_DIV_DIVIDEND = r_dividend;
    assign O_DIV_DIVISOR  = r_divisor;
    assign O_RSP_VLD      = (r_state == S_DONE);
    assign O_RSP_ID       = r_id;
    assign O_RSP_QUOTIENT = r_quot;
    assign O_RSP_DIV0     = r_div0 && (r_state == S_DONE);
    assign O_BUSY         = (r_state != S_IDLE);

endmodule

// File: tb/tb_div_share_arb.sv
// Self-checking bench for div_share_arb: directed vector table, hand-built
// multi-cycle sequences and a randomized phase against a scoreboard model.
module tb_div_share_arb;

    localparam int D_W   = 16;
    localparam int N_REQ = 4;
    localparam int ID_W  = 2;
    localparam int LAT   = D_W + 16;

    typedef struct {
        int          id;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] q;
        logic        d0;
        int          lat;
    } vec_t;

    typedef struct {
        int          cyc;
        int          id;
        logic [15:0] q;
        logic        d0;
    } rsp_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [N_REQ-1:0]     reqVld = '0;
    logic [N_REQ*D_W-1:0] reqDividend = '0;
    logic [N_REQ*D_W-1:0] reqDivisor = '0;
    logic [N_REQ-1:0]     reqRdy;
    logic                 divStart;
    logic [D_W-1:0]       divDividend;
    logic [D_W-1:0]       divDivisor;
    logic [D_W-1:0]       divQuot;
    logic                 divVld;
    logic                 rspVld;
    logic [ID_W-1:0]      rspId;
    logic [D_W-1:0]       rspQuot;
    logic                 rspDiv0;
    logic                 busy;

    int nChecks = 0;
    int nFails  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    div_share_arb #(
        .D_W   (D_W),
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) dut (
        .I_CLK          (clk),
        .I_RST          (rst),
        .I_REQ_VLD      (reqVld),
        .I_REQ_DIVIDEND (reqDividend),
        .I_REQ_DIVISOR  (reqDivisor),
        .O_REQ_RDY      (reqRdy),
        .O_DIV_START    (divStart),
        .O_DIV_DIVIDEND (divDividend),
        .O_DIV_DIVISOR  (divDivisor),
        .I_DIV_QUOTIENT (divQuot),
        .I_DIV_VLD      (divVld),
        .O_RSP_VLD      (rspVld),
        .O_RSP_ID       (rspId),
        .O_RSP_QUOTIENT (rspQuot),
        .O_RSP_DIV0     (rspDiv0),
        .O_BUSY         (busy)
    );

    // Fixed-point division as the real divider computes it (Q2.13, truncating, clamped).
    function automatic logic [15:0] refQuot(input logic [15:0] a, input logic [15:0] b);
        longint n, d, q;
        n = longint'($signed(a)) * 8192;
        d = longint'($signed(b));
        q = n / d;
        if (q > 32767) q = 32767;
        if (q < -32768) q = -32768;
        return q[15:0];
    endfunction

    function automatic logic [15:0] satRef(input logic [15:0] a);
        return a[15] ? 16'h8000 : 16'h7FFF;
    endfunction

    function automatic int onehotIdx(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Behavioural divider: done pulse in the (D_W+15)th cycle of a held start,
    // plus optional stray done pulses whenever start is low.
    int          divCnt = 0;
    logic        mdlVld = 1'b0;
    logic [15:0] mdlQ = '0;
    logic        strayOn = 1'b0;
    logic        strayPulse = 1'b0;
    logic [15:0] strayQ = '0;

    always @(posedge clk) begin
        strayPulse <= ($urandom_range(0, 5) == 0);
        strayQ     <= 16'($urandom);
        if (divStart) begin
            divCnt <= divCnt + 1;
            mdlVld <= (divCnt == D_W + 13);
            mdlQ   <= refQuot(divDividend, divDivisor);
        end else begin
            divCnt <= 0;
            mdlVld <= 1'b0;
        end
    end

    assign divVld  = mdlVld | (strayOn & ~divStart & strayPulse);
    assign divQuot = mdlVld ? mdlQ : strayQ;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input int id, input logic [15:0] a, input logic [15:0] b);
        reqVld[id]                = 1'b1;
        reqDividend[id*D_W +: D_W] = a;
        reqDivisor[id*D_W +: D_W]  = b;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst    = 1'b1;
        reqVld = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Looks for a grant starting in the current cycle; drops the request once accepted.
    task automatic waitGrant(output int idx, output int gcyc);
        bit ok;
        ok   = 1'b0;
        idx  = 0;
        gcyc = 0;
        for (int k = 0; k < 200; k++) begin
            #1;
            if (reqRdy != '0) begin
                ok   = 1'b1;
                gcyc = cyc;
                idx  = onehotIdx(reqRdy);
                break;
            end
            @(negedge clk);
        end
        checkOutput("grantSeen", 32'(ok), 32'd1);
        if (ok) begin
            checkOutput("grantOneHot", $countones(reqRdy), 32'd1);
            @(posedge clk);
            #1;
            if (idx >= 0) reqVld[idx] = 1'b0;
        end
    endtask

    task automatic waitRsp(output int rcyc, output logic [1:0] id, output logic [15:0] q,
                           output logic d0, output bit sawStart);
        bit ok;
        ok       = 1'b0;
        sawStart = 1'b0;
        rcyc     = 0;
        id       = '0;
        q        = '0;
        d0       = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (divStart) sawStart = 1'b1;
            if (rspVld) begin
                ok   = 1'b1;
                rcyc = cyc;
                id   = rspId;
                q    = rspQuot;
                d0   = rspDiv0;
                break;
            end
        end
        checkOutput("rspSeen", 32'(ok), 32'd1);
    endtask

    task automatic runVector(input string tag, input vec_t v);
        int          idx, gcyc, rcyc;
        logic [1:0]  id;
        logic [15:0] q;
        logic        d0;
        bit          sawStart;
        @(negedge clk);
        applyStimulus(v.id, v.a, v.b);
        waitGrant(idx, gcyc);
        checkOutput({tag, ".grantId"}, idx, v.id);
        waitRsp(rcyc, id, q, d0, sawStart);
        checkOutput({tag, ".latency"}, rcyc - gcyc, v.lat);
        checkOutput({tag, ".rspId"}, 32'(id), v.id);
        checkOutput({tag, ".quotient"}, 32'(q), 32'(v.q));
        checkOutput({tag, ".div0"}, 32'(d0), 32'(v.d0));
        checkOutput({tag, ".startRose"}, 32'(sawStart), 32'(!v.d0));
    endtask

    vec_t vecs[8];
    int   expOrd[5];
    rsp_t expQ[$];

    initial begin
        int          idx, gcyc, g0, g3, r1, r2, lowCnt, spur, ptr, freeCyc, winner, lat;
        logic [1:0]  id2;
        logic [15:0] q2, a, b;
        logic [3:0]  expGnt, accMask;
        rsp_t        e;

        vecs[0] = '{0, 16'h2000, 16'h4000, 16'h1000, 1'b0, LAT};
        vecs[1] = '{1, 16'hE000, 16'h0000, 16'h8000, 1'b1, 1};
        vecs[2] = '{2, 16'hE000, 16'h4000, 16'hF000, 1'b0, LAT};
        vecs[3] = '{3, 16'h1234, 16'h0000, 16'h7FFF, 1'b1, 1};
        vecs[4] = '{1, 16'h4000, 16'h2000, 16'h4000, 1'b0, LAT};
        vecs[5] = '{2, 16'h0800, 16'hF000, 16'hF000, 1'b0, LAT};
        vecs[6] = '{0, 16'h8000, 16'h0000, 16'h8000, 1'b1, 1};
        vecs[7] = '{3, 16'h0000, 16'h0000, 16'h7FFF, 1'b1, 1};
        expOrd  = '{0, 1, 2, 3, 0};

        $display("[TB] reset values");
        doReset();
        #1;
        checkOutput("rst.reqRdy", 32'(reqRdy), 0);
        checkOutput("rst.divStart", 32'(divStart), 0);
        checkOutput("rst.divDividend", 32'(divDividend), 0);
        checkOutput("rst.divDivisor", 32'(divDivisor), 0);
        checkOutput("rst.rspVld", 32'(rspVld), 0);
        checkOutput("rst.rspId", 32'(rspId), 0);
        checkOutput("rst.rspQuot", 32'(rspQuot), 0);
        checkOutput("rst.rspDiv0", 32'(rspDiv0), 0);
        checkOutput("rst.busy", 32'(busy), 0);

        $display("[TB] vector table");
        for (int i = 0; i < 8; i++) runVector($sformatf("vec%0d", i), vecs[i]);

        $display("[TB] round-robin order");
        doReset();
        for (int i = 0; i < 4; i++) applyStimulus(i, 16'(16'h1000 * (i + 1)), 16'h4000);
        for (int i = 0; i < 5; i++) begin
            waitGrant(idx, gcyc);
            checkOutput($sformatf("rrOrder%0d", i), idx, expOrd[i]);
            if (i == 0) reqVld[0] = 1'b1;
        end
        applyStimulus(1, 16'h2000, 16'h4000);
        applyStimulus(3, 16'h2000, 16'h4000);
        waitGrant(idx, gcyc);
        checkOutput("rrLate.first", idx, 1);
        applyStimulus(2, 16'h2000, 16'h4000);
        waitGrant(idx, gcyc);
        checkOutput("rrLate.second", idx, 2);
        waitGrant(idx, gcyc);
        checkOutput("rrLate.third", idx, 3);
        repeat (40) @(negedge clk);

        $display("[TB] back-to-back");
        doReset();
        applyStimulus(0, 16'h2000, 16'h4000);
        applyStimulus(3, 16'hE000, 16'h4000);
        waitGrant(idx, g0);
        checkOutput("b2b.firstId", idx, 0);
        g3 = -1; r1 = -1; r2 = -1; lowCnt = 0; id2 = '0; q2 = '0;
        for (int k = 0; k < 100 && r2 < 0; k++) begin
            @(negedge clk);
            #1;
            if (g3 >= 0) reqVld[3] = 1'b0;
            if (reqRdy[3] && g3 < 0) g3 = cyc;
            if (rspVld) begin
                if (r1 < 0) r1 = cyc;
                else begin
                    r2  = cyc;
                    id2 = rspId;
                    q2  = rspQuot;
                end
            end
            if (r2 < 0 && !divStart) lowCnt++;
        end
        checkOutput("b2b.firstLatency", r1 - g0, LAT);
        checkOutput("b2b.grantInDone", g3, r1);
        checkOutput("b2b.startLowOnce", lowCnt, 1);
        checkOutput("b2b.spacing", r2 - r1, LAT);
        checkOutput("b2b.secondId", 32'(id2), 3);
        checkOutput("b2b.secondQuot", 32'(q2), 32'h0000F000);

        $display("[TB] reset mid-operation");
        doReset();
        applyStimulus(1, 16'h2000, 16'h4000);
        waitGrant(idx, gcyc);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("midRst.divStart", 32'(divStart), 0);
        checkOutput("midRst.busy", 32'(busy), 0);
        checkOutput("midRst.rspVld", 32'(rspVld), 0);
        rst  = 1'b0;
        spur = 0;
        repeat (50) begin
            @(negedge clk);
            if (rspVld) spur++;
        end
        checkOutput("midRst.noStaleRsp", spur, 0);
        runVector("midRst.fresh", '{2, 16'h2000, 16'h4000, 16'h1000, 1'b0, LAT});

        $display("[TB] randomized traffic");
        doReset();
        strayOn = 1'b1;
        ptr     = 0;
        freeCyc = 0;
        accMask = '0;
        expQ.delete();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            reqVld  = reqVld & ~accMask;
            accMask = '0;
            if (c < 2700) begin
                for (int i = 0; i < 4; i++) begin
                    if (!reqVld[i] && $urandom_range(0, 3) == 0)
                        applyStimulus(i, 16'($urandom),
                                      ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom));
                end
            end
            #1;
            if (expQ.size() > 0 && expQ[0].cyc == cyc) begin
                e = expQ.pop_front();
                checkOutput("rnd.rspVld", 32'(rspVld), 1);
                checkOutput("rnd.rspId", 32'(rspId), e.id);
                checkOutput("rnd.rspQuot", 32'(rspQuot), 32'(e.q));
                checkOutput("rnd.rspDiv0", 32'(rspDiv0), 32'(e.d0));
            end else begin
                checkOutput("rnd.noRsp", 32'(rspVld), 0);
            end
            expGnt = '0;
            winner = -1;
            if (cyc >= freeCyc) begin
                for (int k = 0; k < 4; k++) begin
                    if (winner < 0 && reqVld[(ptr + k) % 4]) winner = (ptr + k) % 4;
                end
            end
            if (winner >= 0) expGnt[winner] = 1'b1;
            checkOutput("rnd.grant", 32'(reqRdy), 32'(expGnt));
            if (winner >= 0) begin
                a     = reqDividend[winner*D_W +: D_W];
                b     = reqDivisor[winner*D_W +: D_W];
                lat   = (b == 16'h0000) ? 1 : LAT;
                e.cyc = cyc + lat;
                e.id  = winner;
                e.d0  = (b == 16'h0000);
                e.q   = e.d0 ? satRef(a) : refQuot(a, b);
                expQ.push_back(e);
                ptr     = (winner + 1) % 4;
                freeCyc = cyc + lat;
                accMask = expGnt;
            end
        end
        checkOutput("rnd.drained", expQ.size(), 0);
        strayOn = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
